// File: rtl/music_sequencer.sv
// ============================================================================
// Module   : music_sequencer
// Fetches note entries from a synchronous song ROM and drives the note-length
// timer and tone generator, with play/stop, rests, end markers and looping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module music_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter int          PITCH_W    = 6,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 play,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic                 note_change,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PITCH_W+3:0]   rom_data,
    output logic [3:0]           length,
    output logic [PITCH_W-1:0]   pitch,
    output logic                 tone_en,
    output logic                 busy,
    output logic                 song_done
);

    localparam logic [ADDR_W-1:0] c_START = ADDR_W'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [3:0]           r_length;
    logic [PITCH_W-1:0]   r_pitch;
    logic                 r_tone_en;
    logic                 r_busy;
    logic                 r_song_done;
    logic                 r_played_any;

    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic [3:0]           w_length_nxt;
    logic [PITCH_W-1:0]   w_pitch_nxt;
    logic                 w_tone_en_nxt;
    logic                 w_song_done_nxt;
    logic                 w_played_any_nxt;

    logic [3:0]           w_code;
    logic                 w_is_end;

    assign w_code   = rom_data[PITCH_W+3:PITCH_W];
    assign w_is_end = (w_code[2:0] == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= c_START;
            r_length     <= 4'd0;
            r_pitch      <= '0;
            r_tone_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_song_done  <= 1'b0;
            r_played_any <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_length     <= w_length_nxt;
            r_pitch      <= w_pitch_nxt;
            r_tone_en    <= w_tone_en_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_song_done  <= w_song_done_nxt;
            r_played_any <= w_played_any_nxt;
        end
    end

    // stop outranks play, and both outrank whatever the current state wants
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_length_nxt     = r_length;
        w_pitch_nxt      = r_pitch;
        w_tone_en_nxt    = r_tone_en;
        w_song_done_nxt  = 1'b0;
        w_played_any_nxt = r_played_any;

        if (stop) begin
            w_state_nxt   = S_IDLE;
            w_length_nxt  = 4'd0;
            w_tone_en_nxt = 1'b0;
        end else if (play) begin
            w_state_nxt      = S_FETCH;
            w_addr_nxt       = c_START;
            w_played_any_nxt = 1'b0;
            w_length_nxt     = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_length_nxt  = 4'd0;
                    w_tone_en_nxt = 1'b0;
                end
                S_FETCH: begin
                    w_state_nxt  = S_LOAD;
                    w_length_nxt = 4'd0;
                end
                S_LOAD: begin
                    if (w_is_end) begin
                        // played_any guards against spinning forever on an empty looped song
                        if (r_played_any && loop_en) begin
                            w_state_nxt      = S_FETCH;
                            w_addr_nxt       = c_START;
                            w_played_any_nxt = 1'b0;
                        end else begin
                            w_state_nxt     = S_IDLE;
                            w_song_done_nxt = 1'b1;
                            w_tone_en_nxt   = 1'b0;
                            w_length_nxt    = 4'd0;
                        end
                    end else begin
                        w_state_nxt      = S_PLAY;
                        w_length_nxt     = {1'b0, w_code[2:0]};
                        w_pitch_nxt      = rom_data[PITCH_W-1:0];
                        w_tone_en_nxt    = ~w_code[3];
                        w_played_any_nxt = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (note_change) begin
                        w_state_nxt  = S_FETCH;
                        w_addr_nxt   = r_addr + ADDR_W'(1);
                        w_length_nxt = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = r_addr;
    assign length    = r_length;
    assign pitch     = r_pitch;
    assign tone_en   = r_tone_en;
    assign busy      = r_busy;
    assign song_done = r_song_done;

endmodule

`default_nettype wire

// File: tb/tb_music_sequencer.sv
// ============================================================================
// Module   : tb_music_sequencer
// Self-checking bench: behavioural song-player model plus directed scenarios.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_music_sequencer;

    localparam int AW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          play = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          note_change = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [PW+3:0] rom_data = '0;
    logic [3:0]    length;
    logic [PW-1:0] pitch;
    logic          tone_en;
    logic          busy;
    logic          song_done;

    logic [PW+3:0] mem [0:255];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit cmp_en   = 1'b0;

    // model of the player: phase 2 = address issued, 1 = entry arriving, 0 = sounding
    bit            m_active;
    int            m_phase;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_len;
    logic [PW-1:0] m_pitch;
    bit            m_tone;
    bit            m_done;
    bit            m_played;

    music_sequencer #(.ADDR_W(AW), .PITCH_W(PW), .START_ADDR(0)) dut (
        .clk(clk), .rst(rst), .play(play), .stop(stop), .loop_en(loop_en),
        .note_change(note_change), .rom_addr(rom_addr), .rom_data(rom_data),
        .length(length), .pitch(pitch), .tone_en(tone_en), .busy(busy),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    always @(negedge clk) if (song_done) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_active = 0; m_phase = 0; m_addr = '0; m_len = '0;
        m_pitch = '0; m_tone = 0; m_done = 0; m_played = 0;
    endtask

    task automatic m_step();
        logic [PW+3:0] e;
        m_done = 0;
        if (stop) begin
            m_active = 0; m_len = 0; m_tone = 0;
        end else if (play) begin
            m_active = 1; m_phase = 2; m_addr = '0; m_played = 0; m_len = 0;
        end else if (!m_active) begin
            m_len = 0; m_tone = 0;
        end else if (m_phase == 2) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            e = mem[m_addr];
            if (e[PW+2:PW] == 3'd0) begin
                if (m_played && loop_en) begin
                    m_addr = '0; m_played = 0; m_phase = 2;
                end else begin
                    m_active = 0; m_done = 1; m_tone = 0; m_len = 0;
                end
            end else begin
                m_len    = {1'b0, e[PW+2:PW]};
                m_pitch  = e[PW-1:0];
                m_tone   = !e[PW+3];
                m_played = 1;
                m_phase  = 0;
            end
        end else if (note_change) begin
            m_addr = m_addr + 8'd1; m_len = 0; m_phase = 2;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("rom_addr",  int'(rom_addr),  int'(m_addr));
                chk("length",    int'(length),    int'(m_len));
                chk("pitch",     int'(pitch),     int'(m_pitch));
                chk("tone_en",   int'(tone_en),   int'(m_tone));
                chk("busy",      int'(busy),      int'(m_active));
                chk("song_done", int'(song_done), int'(m_done));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic play_pulse();
        play = 1'b1; @(negedge clk); play = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic nc_pulse();
        note_change = 1'b1; @(negedge clk); note_change = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic song_two_notes();
        clear_mem();
        mem[0] = {4'd3, 6'd24};
        mem[1] = {4'd2, 6'd28};
    endtask

    initial begin
        int dc;
        clear_mem();
        rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_len",  int'(length), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(song_done), 0);
        rst = 1'b0;
        cyc(1);

        // two notes then end, no loop
        song_two_notes();
        loop_en = 1'b0;
        play_pulse();
        chk("t1_fetch_busy", int'(busy), 1);
        chk("t1_fetch_len", int'(length), 0);
        cyc(2);
        chk("t1_n1_len", int'(length), 3);
        chk("t1_n1_pitch", int'(pitch), 24);
        chk("t1_n1_tone", int'(tone_en), 1);
        cyc(4);
        chk("t1_n1_hold", int'(length), 3);
        nc_pulse();
        chk("t1_gap1", int'(length), 0);
        cyc(1);
        chk("t1_gap2", int'(length), 0);
        cyc(1);
        chk("t1_n2_len", int'(length), 2);
        chk("t1_n2_pitch", int'(pitch), 28);
        dc = done_cnt;
        nc_pulse();
        cyc(2);
        chk("t1_done", int'(song_done), 1);
        chk("t1_idle", int'(busy), 0);
        cyc(1);
        chk("t1_done_once", int'(song_done), 0);
        chk("t1_len_idle", int'(length), 0);
        chk("t1_done_cnt", done_cnt - dc, 1);

        // rest then note
        clear_mem();
        mem[0] = {4'b1100, 6'd10};
        mem[1] = {4'd3, 6'd12};
        play_pulse();
        cyc(2);
        chk("t2_rest_len", int'(length), 4);
        chk("t2_rest_tone", int'(tone_en), 0);
        nc_pulse();
        cyc(2);
        chk("t2_note_len", int'(length), 3);
        chk("t2_note_tone", int'(tone_en), 1);
        chk("t2_note_pitch", int'(pitch), 12);
        stop_pulse();
        chk("t2_stop", int'(busy), 0);

        // looping two-note song, three passes
        clear_mem();
        mem[0] = {4'd1, 6'd5};
        mem[1] = {4'd2, 6'd6};
        loop_en = 1'b1;
        dc = done_cnt;
        play_pulse();
        for (int l = 0; l < 3; l++) begin
            cyc(2);
            chk("t3_n1_len", int'(length), 1);
            cyc(3);
            nc_pulse();
            cyc(2);
            chk("t3_n2_len", int'(length), 2);
            nc_pulse();
            chk("t3_end_addr", int'(rom_addr), 2);
            cyc(2);
            chk("t3_wrap_addr", int'(rom_addr), 0);
            chk("t3_wrap_busy", int'(busy), 1);
        end
        chk("t3_no_done", done_cnt - dc, 0);
        stop_pulse();

        // empty song with loop enabled must not refetch forever
        clear_mem();
        dc = done_cnt;
        play_pulse();
        cyc(2);
        chk("t4_done", int'(song_done), 1);
        chk("t4_idle", int'(busy), 0);
        cyc(5);
        chk("t4_still_idle", int'(busy), 0);
        chk("t4_addr", int'(rom_addr), 0);
        chk("t4_done_cnt", done_cnt - dc, 1);
        loop_en = 1'b0;

        // stop and play together while playing
        song_two_notes();
        dc = done_cnt;
        play_pulse();
        cyc(2);
        nc_pulse();
        cyc(2);
        stop = 1'b1; play = 1'b1;
        @(negedge clk);
        stop = 1'b0; play = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_len", int'(length), 0);
        chk("t5_tone", int'(tone_en), 0);
        chk("t5_addr", int'(rom_addr), 1);
        cyc(2);
        chk("t5_no_done", done_cnt - dc, 0);

        // restart while playing address 5
        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = {4'd3, 6'(i + 1)};
        play_pulse();
        cyc(2);
        repeat (5) begin
            nc_pulse();
            cyc(2);
        end
        chk("t6_addr5", int'(rom_addr), 5);
        chk("t6_pitch5", int'(pitch), 6);
        play_pulse();
        chk("t6_restart_addr", int'(rom_addr), 0);
        chk("t6_restart_busy", int'(busy), 1);
        chk("t6_restart_len", int'(length), 0);
        cyc(2);
        chk("t6_first_pitch", int'(pitch), 1);

        // asynchronous reset in the middle of a ROM load
        play_pulse();
        cyc(2);
        nc_pulse();
        cyc(1);
        #2 rst = 1'b1;
        #1;
        chk("t7_addr", int'(rom_addr), 0);
        chk("t7_len", int'(length), 0);
        chk("t7_pitch", int'(pitch), 0);
        chk("t7_tone", int'(tone_en), 0);
        chk("t7_busy", int'(busy), 0);
        chk("t7_done", int'(song_done), 0);
        @(negedge clk);
        rst = 1'b0;

        // randomized songs and commands against the model
        for (int r = 0; r < 6; r++) begin
            rst = 1'b1;
            for (int i = 0; i < 256; i++) mem[i] = 10'($urandom);
            if (r < 3) for (int i = 0; i < 12; i++) mem[i][PW+2:PW] = 3'($urandom_range(1, 7));
            @(negedge clk);
            rst = 1'b0;
            repeat (2000) begin
                play        = ($urandom_range(0, 99) < 2);
                stop        = ($urandom_range(0, 99) < 1);
                note_change = ($urandom_range(0, 99) < 20);
                if ($urandom_range(0, 99) < 2) loop_en = ~loop_en;
                @(negedge clk);
            end
            play = 1'b0; stop = 1'b0; note_change = 1'b0;
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
